mem_arbiter: RTL

- Shares the single processor-memory port between the instruction-cache miss path and the data-cache miss/store path.
- Picks one requester per cycle and drives the memory command bus.
- Records which requester owns each outstanding memory transaction tag.
- Routes each tagged memory response back to the requester that owns it.
- Sits between the two caches and the memory model, below the branch predictor and BTB cache structures.

---
 rtl/mem_arbiter_pkg.sv | 24 ++
 rtl/mem_arbiter_if.sv | 53 +++++
 rtl/mem_arbiter_tag_table.sv | 39 +++
 rtl/mem_arbiter.sv | 107 ++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared bus definitions for the processor-memory port: command encoding,
// tag sizing and the owner-table entry layout.
package sys_defs;

    localparam int MEM_TAG_W = 4;
    localparam int NUM_TAGS  = 16;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'b00,
        BUS_LOAD  = 2'b01,
        BUS_STORE = 2'b10
    } BUS_COMMAND;

    typedef enum logic {
        OWNER_ICACHE = 1'b0,
        OWNER_DCACHE = 1'b1
    } MEM_OWNER;

    typedef struct packed {
        logic     valid;
        MEM_OWNER owner;
    } ARB_TAG_ENTRY;

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-side and memory-side signals of the arbiter. The arbiter attaches
// through the slave modport; the caches and memory model use the master one.
interface mem_arbiter_if;
    import sys_defs::*;

    logic                 icache_req_valid;
    logic [31:0]          icache_req_addr;
    logic                 icache_req_accepted;
    logic [MEM_TAG_W-1:0] icache_req_tag;
    logic                 icache_rsp_valid;
    logic [MEM_TAG_W-1:0] icache_rsp_tag;
    logic [63:0]          icache_rsp_data;

    logic                 dcache_req_valid;
    BUS_COMMAND           dcache_req_command;
    logic [31:0]          dcache_req_addr;
    logic [63:0]          dcache_req_data;
    logic                 dcache_req_accepted;
    logic [MEM_TAG_W-1:0] dcache_req_tag;
    logic                 dcache_rsp_valid;
    logic [MEM_TAG_W-1:0] dcache_rsp_tag;
    logic [63:0]          dcache_rsp_data;

    BUS_COMMAND           proc2mem_command;
    logic [31:0]          proc2mem_addr;
    logic [63:0]          proc2mem_data;
    logic [MEM_TAG_W-1:0] mem2proc_transaction_tag;
    logic [63:0]          mem2proc_data;
    logic [MEM_TAG_W-1:0] mem2proc_data_tag;

    modport slave (
        input  icache_req_valid, icache_req_addr,
        output icache_req_accepted, icache_req_tag,
        output icache_rsp_valid, icache_rsp_tag, icache_rsp_data,
        input  dcache_req_valid, dcache_req_command, dcache_req_addr, dcache_req_data,
        output dcache_req_accepted, dcache_req_tag,
        output dcache_rsp_valid, dcache_rsp_tag, dcache_rsp_data,
        output proc2mem_command, proc2mem_addr, proc2mem_data,
        input  mem2proc_transaction_tag, mem2proc_data, mem2proc_data_tag
    );

    modport master (
        output icache_req_valid, icache_req_addr,
        input  icache_req_accepted, icache_req_tag,
        input  icache_rsp_valid, icache_rsp_tag, icache_rsp_data,
        output dcache_req_valid, dcache_req_command, dcache_req_addr, dcache_req_data,
        input  dcache_req_accepted, dcache_req_tag,
        input  dcache_rsp_valid, dcache_rsp_tag, dcache_rsp_data,
        input  proc2mem_command, proc2mem_addr, proc2mem_data,
        output mem2proc_transaction_tag, mem2proc_data, mem2proc_data_tag
    );

endinterface

// File: rtl/mem_arbiter_tag_table.sv
// Owner table for outstanding memory load tags: which cache issued each load.
// Allocation is written after the free so a same-edge reuse of a tag keeps the new owner.
module mem_tag_table
    import sys_defs::*;
#(
    parameter int DEPTH = NUM_TAGS
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 alloc_en,
    input  logic [MEM_TAG_W-1:0] alloc_tag,
    input  MEM_OWNER             alloc_owner,
    input  logic [MEM_TAG_W-1:0] lookup_tag,
    output ARB_TAG_ENTRY         lookup_entry,
    input  logic                 free_en,
    input  logic [MEM_TAG_W-1:0] free_tag
);

    ARB_TAG_ENTRY entry_q [DEPTH];

    assign lookup_entry = entry_q[lookup_tag];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
            end
        end else begin
            if (free_en && (free_tag != '0)) begin
                entry_q[free_tag].valid <= 1'b0;
            end
            // Tag 0 means "not accepted", so slot 0 is never populated.
            if (alloc_en && (alloc_tag != '0)) begin
                entry_q[alloc_tag] <= '{valid: 1'b1, owner: alloc_owner};
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the processor-memory port between icache and dcache: same-cycle
// arbitration with an icache anti-starvation counter, and tag-based response routing.
module mem_arbiter
    import sys_defs::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic         clock,
    input  logic         reset,
    mem_arbiter_if.slave bus
);

    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    logic [STARVE_W-1:0] starve_cnt;
    logic                grant_icache;
    logic                grant_dcache;
    logic                mem_accepted;
    BUS_COMMAND          issue_cmd;
    logic [31:0]         issue_addr;
    logic [63:0]         issue_data;
    ARB_TAG_ENTRY        lookup_entry;
    logic                rsp_hit;
    logic                rsp_icache;
    logic                rsp_dcache;

    // Everything is gated by reset so outputs sit at their idle values while it is held.
    always_comb begin
        grant_icache = 1'b0;
        grant_dcache = 1'b0;
        if (!reset) begin
            if (bus.dcache_req_valid && bus.icache_req_valid) begin
                if (starve_cnt == STARVE_MAX) begin
                    grant_icache = 1'b1;
                end else begin
                    grant_dcache = 1'b1;
                end
            end else if (bus.dcache_req_valid) begin
                grant_dcache = 1'b1;
            end else if (bus.icache_req_valid) begin
                grant_icache = 1'b1;
            end
        end
    end

    always_comb begin
        issue_cmd  = BUS_NONE;
        issue_addr = '0;
        issue_data = '0;
        if (grant_dcache) begin
            issue_cmd  = bus.dcache_req_command;
            issue_addr = bus.dcache_req_addr;
            issue_data = bus.dcache_req_data;
        end else if (grant_icache) begin
            issue_cmd  = BUS_LOAD;
            issue_addr = bus.icache_req_addr;
        end
    end

    assign mem_accepted = (grant_icache || grant_dcache) && (bus.mem2proc_transaction_tag != '0);

    assign bus.proc2mem_command    = issue_cmd;
    assign bus.proc2mem_addr       = issue_addr;
    assign bus.proc2mem_data       = issue_data;
    assign bus.icache_req_accepted = grant_icache && mem_accepted;
    assign bus.dcache_req_accepted = grant_dcache && mem_accepted;
    assign bus.icache_req_tag      = bus.icache_req_accepted ? bus.mem2proc_transaction_tag : '0;
    assign bus.dcache_req_tag      = bus.dcache_req_accepted ? bus.mem2proc_transaction_tag : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (!bus.icache_req_valid || bus.icache_req_accepted) begin
            starve_cnt <= '0;
        end else if (bus.dcache_req_accepted && (starve_cnt != STARVE_MAX)) begin
            starve_cnt <= starve_cnt + STARVE_W'(1);
        end
    end

    mem_tag_table #(
        .DEPTH (NUM_TAGS)
    ) u_tag_table (
        .clock        (clock),
        .reset        (reset),
        .alloc_en     (mem_accepted && (issue_cmd == BUS_LOAD)),
        .alloc_tag    (bus.mem2proc_transaction_tag),
        .alloc_owner  (grant_icache ? OWNER_ICACHE : OWNER_DCACHE),
        .lookup_tag   (bus.mem2proc_data_tag),
        .lookup_entry (lookup_entry),
        .free_en      (rsp_hit),
        .free_tag     (bus.mem2proc_data_tag)
    );

    // Routing reads the table before this edge's write, so a reused tag answers its old owner.
    assign rsp_hit    = !reset && (bus.mem2proc_data_tag != '0) && lookup_entry.valid;
    assign rsp_icache = rsp_hit && (lookup_entry.owner == OWNER_ICACHE);
    assign rsp_dcache = rsp_hit && (lookup_entry.owner == OWNER_DCACHE);

    assign bus.icache_rsp_valid = rsp_icache;
    assign bus.icache_rsp_tag   = rsp_icache ? bus.mem2proc_data_tag : '0;
    assign bus.icache_rsp_data  = rsp_icache ? bus.mem2proc_data : '0;
    assign bus.dcache_rsp_valid = rsp_dcache;
    assign bus.dcache_rsp_tag   = rsp_dcache ? bus.mem2proc_data_tag : '0;
    assign bus.dcache_rsp_data  = rsp_dcache ? bus.mem2proc_data : '0;

endmodule
